// File: rtl/tx_backend_interp_if.sv
// -----------------------------------------------------------------------------
// tx_backend_interp_if
//
// Purpose: groups the sample-input handshake and the DAC-side signals of
//          tx_backend_interp into one bundle.
//
// Parameters (must match the tx_backend_interp instance they are bound to):
//   INPUT_WIDTH   signed baseband sample width
//   OUTPUT_WIDTH  DAC code width
//
// Signals:
//   s_data     signed two's-complement baseband sample  (source -> block)
//   s_valid    s_data valid                              (source -> block)
//   s_ready    block accepts s_data this cycle           (block -> source)
//   out_en     output-rate strobe, one DAC update/cycle  (source -> block)
//   dac_out    offset-binary DAC code                    (block -> source)
//   dac_valid  one-cycle pulse when dac_out updates      (block -> source)
//   underflow  one-cycle pulse on entry to STARVE        (block -> source)
//   active     high while interpolating (RUN)            (block -> source)
//
// Modports: master = sample source / DAC consumer side, slave = the block.
// -----------------------------------------------------------------------------
interface tx_backend_interp_if #(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 8
);
  logic signed [INPUT_WIDTH-1:0] s_data;
  logic                          s_valid;
  logic                          s_ready;
  logic                          out_en;
  logic [OUTPUT_WIDTH-1:0]       dac_out;
  logic                          dac_valid;
  logic                          underflow;
  logic                          active;

  modport master (
    output s_data, s_valid, out_en,
    input  s_ready, dac_out, dac_valid, underflow, active
  );

  modport slave (
    input  s_data, s_valid, out_en,
    output s_ready, dac_out, dac_valid, underflow, active
  );
endinterface

// File: rtl/tx_backend_interp.sv
// -----------------------------------------------------------------------------
// tx_backend_interp
//
// Purpose: transmit back-end that takes signed baseband samples through a
//          4-entry FIFO, linearly interpolates between consecutive samples by
//          a factor L = 2^INTERP_LOG2 (one output per out_en strobe) and
//          converts the result to an offset-binary DAC code.
//
// Parameters:
//   INPUT_WIDTH   signed sample width (>= OUTPUT_WIDTH+1), default 12
//   OUTPUT_WIDTH  DAC code width, default 8
//   INTERP_LOG2   log2 of interpolation factor L (1..6), default 3
//
// Ports:
//   clk_in  input   sole clock, rising edge
//   RST     input   synchronous active-high reset
//   bus     tx_backend_interp_if.slave
//             s_data/s_valid/s_ready : sample input handshake
//             out_en                 : output-rate strobe
//             dac_out/dac_valid      : registered DAC code + update pulse
//             underflow              : pulse when interpolation starves
//             active                 : high in RUN
//
// Build option:
//   TX_BACKEND_ROUND_EN  when defined, the code is rounded to nearest
//                        (half-LSB bias, saturating at max positive) before
//                        the low bits are dropped; otherwise plain truncation.
// -----------------------------------------------------------------------------
module tx_backend_interp #(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 8,
  parameter int INTERP_LOG2  = 3
) (
  input  logic                clk_in,
  input  logic                RST,
  tx_backend_interp_if.slave  bus
);

  localparam int FIFO_DEPTH = 4;
  // Product width: (INPUT_WIDTH+1)-bit difference times (INTERP_LOG2+1)-bit
  // non-negative phase, so no intermediate result can overflow.
  localparam int PW   = INPUT_WIDTH + INTERP_LOG2 + 2;
  localparam int DROP = INPUT_WIDTH - OUTPUT_WIDTH;

  localparam logic [INTERP_LOG2-1:0]  K_MAX    = '1;
  localparam logic [OUTPUT_WIDTH-1:0] MIDSCALE = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_STARVE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic signed [INPUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [1:0]                    r_wr_ptr;
  logic [1:0]                    r_rd_ptr;
  logic [2:0]                    r_count;

  logic                          w_ready;
  logic                          w_push;
  logic                          w_pop;
  logic signed [INPUT_WIDTH-1:0] w_head;

  assign w_ready     = (r_count < 3'd4);
  assign bus.s_ready = w_ready;
  assign w_push      = bus.s_valid && w_ready;
  assign w_head      = r_mem[r_rd_ptr];

  // Storage is not reset: pointers and count alone define what is valid, so a
  // write landing during RST is simply never read.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.s_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Interpolator state
  // ---------------------------------------------------------------------------
  state_t                        r_state;
  logic signed [INPUT_WIDTH-1:0] r_a;
  logic signed [INPUT_WIDTH-1:0] r_b;
  logic [INTERP_LOG2-1:0]        r_k;
  logic [OUTPUT_WIDTH-1:0]       r_dac_out;
  logic                          r_dac_valid;
  logic                          r_underflow;

  state_t                        w_state_next;
  logic signed [INPUT_WIDTH-1:0] w_a_next;
  logic signed [INPUT_WIDTH-1:0] w_b_next;
  logic [INTERP_LOG2-1:0]        w_k_next;
  logic [OUTPUT_WIDTH-1:0]       w_dac_next;
  logic                          w_underflow_next;

  // ---------------------------------------------------------------------------
  // Datapath: y = A + (((B - A) * k) >>> INTERP_LOG2)
  // ---------------------------------------------------------------------------
  logic signed [INPUT_WIDTH:0]   w_diff;
  logic signed [PW-1:0]          w_diff_ext;
  logic signed [PW-1:0]          w_k_ext;
  logic signed [PW-1:0]          w_prod;
  logic signed [INPUT_WIDTH-1:0] w_y;

  assign w_diff     = {r_b[INPUT_WIDTH-1], r_b} - {r_a[INPUT_WIDTH-1], r_a};
  assign w_diff_ext = PW'(w_diff);
  assign w_k_ext    = signed'(PW'(r_k));
  assign w_prod     = w_diff_ext * w_k_ext;
  // The interpolated point always lies between A and B, so it fits in
  // INPUT_WIDTH bits and the upper bits of the sum can be discarded.
  assign w_y        = INPUT_WIDTH'((w_prod >>> INTERP_LOG2) + PW'(r_a));

  // ---------------------------------------------------------------------------
  // Quantiser: STARVE holds the last sample B, RUN emits the interpolant.
  // ---------------------------------------------------------------------------
  logic signed [INPUT_WIDTH-1:0] w_q_in;
  logic [OUTPUT_WIDTH-1:0]       w_q;
  logic [OUTPUT_WIDTH-1:0]       w_code;

  assign w_q_in = (r_state == ST_STARVE) ? r_b : w_y;

`ifdef TX_BACKEND_ROUND_EN
  localparam logic [INPUT_WIDTH:0] ROUND_BIAS = (INPUT_WIDTH+1)'(1) << (DROP - 1);

  logic [INPUT_WIDTH:0] w_rsum;

  // One guard bit catches the only possible overflow: a positive value pushed
  // past max positive by the half-LSB bias. It saturates instead of wrapping.
  assign w_rsum = {w_q_in[INPUT_WIDTH-1], w_q_in} + ROUND_BIAS;
  assign w_q    = (w_rsum[INPUT_WIDTH] != w_rsum[INPUT_WIDTH-1])
                ? {1'b0, {(OUTPUT_WIDTH-1){1'b1}}}
                : OUTPUT_WIDTH'(w_rsum >> DROP);
`else
  assign w_q    = OUTPUT_WIDTH'(w_q_in >>> DROP);
`endif

  // Two's complement to offset binary: flip the sign bit.
  assign w_code = {~w_q[OUTPUT_WIDTH-1], w_q[OUTPUT_WIDTH-2:0]};

  // ---------------------------------------------------------------------------
  // FSM next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_a_next         = r_a;
    w_b_next         = r_b;
    w_k_next         = r_k;
    w_pop            = 1'b0;
    w_underflow_next = 1'b0;
    w_dac_next       = r_dac_out;

    case (r_state)
      ST_IDLE: begin
        if (bus.out_en) begin
          w_dac_next = MIDSCALE;
        end
        // Wait for two samples so PRIME is guaranteed a second one to pop.
        if (r_count >= 3'd2) begin
          w_pop        = 1'b1;
          w_a_next     = w_head;
          w_state_next = ST_PRIME;
        end
      end

      ST_PRIME: begin
        if (bus.out_en) begin
          w_dac_next = MIDSCALE;
        end
        w_pop        = 1'b1;
        w_b_next     = w_head;
        w_k_next     = '0;
        w_state_next = ST_RUN;
      end

      ST_RUN: begin
        if (bus.out_en) begin
          w_dac_next = w_code;
          if (r_k == K_MAX) begin
            w_k_next = '0;
            w_a_next = r_b;
            if (r_count != 3'd0) begin
              w_pop    = 1'b1;
              w_b_next = w_head;
            end else begin
              // Nothing to move towards: hold B and flag the gap once.
              w_state_next     = ST_STARVE;
              w_underflow_next = 1'b1;
            end
          end else begin
            w_k_next = r_k + 1'b1;
          end
        end
      end

      ST_STARVE: begin
        if (bus.out_en) begin
          w_dac_next = w_code;
        end
        // A == B already here, so resuming ramps from the held level to the
        // new sample without a step.
        if (r_count != 3'd0) begin
          w_pop        = 1'b1;
          w_a_next     = r_b;
          w_b_next     = w_head;
          w_k_next     = '0;
          w_state_next = ST_RUN;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_k         <= '0;
      r_dac_out   <= MIDSCALE;
      r_dac_valid <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_a         <= w_a_next;
      r_b         <= w_b_next;
      r_k         <= w_k_next;
      r_dac_out   <= w_dac_next;
      r_dac_valid <= bus.out_en;
      r_underflow <= w_underflow_next;
    end
  end

  assign bus.dac_out   = r_dac_out;
  assign bus.dac_valid = r_dac_valid;
  assign bus.underflow = r_underflow;
  assign bus.active    = (r_state == ST_RUN);

endmodule

// File: tb/tb_tx_backend_interp.sv
// -----------------------------------------------------------------------------
// tb_tx_backend_interp
//
// Bench for tx_backend_interp with INPUT_WIDTH=12, OUTPUT_WIDTH=8,
// INTERP_LOG2=2 (L=4). The stimulus thread queues the hand-computed DAC code
// for every out_en it issues; a monitor thread pops and compares whenever the
// DUT raises dac_valid. Ramp samples are multiples of 64 so their codes do not
// depend on TX_BACKEND_ROUND_EN; the rounding-sensitive cases select their
// expected codes from the same macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tx_backend_interp;

  localparam int IW = 12;
  localparam int OW = 8;
  localparam int IL = 2;

`ifdef TX_BACKEND_ROUND_EN
  localparam logic [7:0] C24   = 8'h82;
  localparam logic [7:0] CNEG  = 8'h42;
  localparam logic [7:0] C1000 = 8'hBF;
`else
  localparam logic [7:0] C24   = 8'h81;
  localparam logic [7:0] CNEG  = 8'h41;
  localparam logic [7:0] C1000 = 8'hBE;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_backend_interp_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

  tx_backend_interp #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW),
    .INTERP_LOG2 (IL)
  ) dut (
    .clk_in(clk),
    .RST   (rst),
    .bus   (bus)
  );

  int         n_tests  = 0;
  int         n_fail   = 0;
  int         uf_count = 0;
  int         n_out    = 0;
  int         uf_base  = 0;
  logic [7:0] exp_q[$];

  logic [7:0] seq30 [12] = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hC0,
                             8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
  logic [7:0] seq32 [12] = '{8'h80, 8'h84, 8'h88, 8'h8C, 8'h90, 8'h94,
                             8'h98, 8'h9C, 8'hA0, 8'hA4, 8'hA8, 8'hAC};

  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.underflow) uf_count++;
      if (bus.dac_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dac_valid", 1, 0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          n_out++;
          $display("[TB] out #%0d dac_out=0x%02h expect=0x%02h", n_out, bus.dac_out, e);
          check($sformatf("dac_out#%0d", n_out), int'(bus.dac_out), int'(e));
        end
      end
    end
  endtask

  task automatic push(input int val);
    bit done;
    done = 1'b0;
    bus.s_data  = IW'(val);
    bus.s_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.s_ready) done = 1'b1;
      tick();
    end
    bus.s_valid = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic strobe(input logic [7:0] code);
    bus.out_en = 1'b1;
    exp_q.push_back(code);
    tick();
    bus.out_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_dac_out",   int'(bus.dac_out), 8'h80);
    check("rst_dac_valid", int'(bus.dac_valid), 0);
    check("rst_underflow", int'(bus.underflow), 0);
    check("rst_active",    int'(bus.active), 0);
    check("rst_s_ready",   int'(bus.s_ready), 1);
  endtask

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.out_en  = 1'b0;
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
      end
    join_none

    tick();
    tick();
    do_reset();

    // Strobes in IDLE give midscale.
    strobe(8'h80);
    strobe(8'h80);
    drain();

    // Ramp 0 -> 1024 then hold at 1024 into STARVE.
    uf_base = uf_count;
    push(0); push(1024); push(1024);
    tick(); tick();
    check("run_active_30", int'(bus.active), 1);
    for (int i = 0; i < 12; i++) begin
      strobe(seq30[i]);
      if (i == 5) check("active_mid_ramp", int'(bus.active), 1);
    end
    drain();
    check("underflow_once_30", uf_count - uf_base, 1);
    check("starve_active_30", int'(bus.active), 0);
    tick(); tick(); tick();
    check("dac_hold", int'(bus.dac_out), 8'hC0);
    check("dac_valid_idle", int'(bus.dac_valid), 0);

    // Starve after one segment, then resume towards 0.
    do_reset();
    uf_base = uf_count;
    push(0); push(1024);
    tick(); tick();
    strobe(8'h80); strobe(8'h90); strobe(8'hA0); strobe(8'hB0); strobe(8'hC0);
    drain();
    check("underflow_once_31", uf_count - uf_base, 1);
    check("starve_active_31", int'(bus.active), 0);
    push(0);
    tick();
    check("resume_active", int'(bus.active), 1);
    strobe(8'hC0); strobe(8'hB0); strobe(8'hA0); strobe(8'h90);
    drain();
    check("underflow_twice_31", uf_count - uf_base, 2);

    // FIFO full back-pressure.
    do_reset();
    push(0); push(256);
    tick(); tick();
    push(512); push(768); push(1024); push(1280);
    check("s_ready_full", int'(bus.s_ready), 0);
    bus.s_data  = IW'(2000);
    bus.s_valid = 1'b1;
    tick(); tick();
    check("s_ready_held_low", int'(bus.s_ready), 0);
    bus.s_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      strobe(seq32[i]);
      if (i == 2) check("s_ready_before_pop", int'(bus.s_ready), 0);
      if (i == 3) check("s_ready_after_pop", int'(bus.s_ready), 1);
    end
    drain();

    // Quantisation corner cases.
    do_reset();
    push(24); push(24);
    tick(); tick();
    strobe(C24); strobe(C24);
    drain();
    do_reset();
    push(2040); push(2040);
    tick(); tick();
    strobe(8'hFF); strobe(8'hFF);
    drain();
    do_reset();
    push(-1000); push(-1000);
    tick(); tick();
    strobe(CNEG); strobe(CNEG);
    drain();

    // Reset during RUN with samples queued; input during RST is dropped.
    do_reset();
    push(0); push(256); push(512); push(768); push(1024);
    strobe(8'h80); strobe(8'h84);
    drain();
    rst         = 1'b1;
    bus.s_data  = IW'(99);
    bus.s_valid = 1'b1;
    tick();
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    check("rst_run_dac_out", int'(bus.dac_out), 8'h80);
    check("rst_run_s_ready", int'(bus.s_ready), 1);
    check("rst_run_active",  int'(bus.active), 0);
    strobe(8'h80); strobe(8'h80); strobe(8'h80);
    push(1000);
    strobe(8'h80); strobe(8'h80);
    check("one_sample_stays_idle", int'(bus.active), 0);
    drain();
    push(1000);
    tick(); tick();
    check("two_samples_run", int'(bus.active), 1);
    strobe(C1000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_backend_interp.md
TX_BACKEND_INTERP -- requirements
Module: tx_backend_interp

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, 12, signed baseband sample width (≥ OUTPUT_WIDTH+1).
REQ-002 SHALL have parameter OUTPUT_WIDTH, 8, DAC code width.
REQ-003 SHALL have parameter INTERP_LOG2, 3, log2 of interpolation factor L (1..6).
REQ-004 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_data  input  INPUT_WIDTH  signed two's-complement baseband sample.
REQ-007 SHALL have port s_valid  input  1  s_data valid.
REQ-008 SHALL have port s_ready  output  1  block accepts s_data this cycle.
REQ-009 SHALL have port out_en  input  1  output-rate strobe, one DAC update per high cycle.
REQ-010 SHALL have port dac_out  output  OUTPUT_WIDTH  offset-binary DAC code.
REQ-011 SHALL have port dac_valid  output  1  one-cycle pulse when dac_out updates.
REQ-012 SHALL have port underflow  output  1  one-cycle pulse on entry to STARVE.
REQ-013 SHALL have port active  output  1  high in RUN state.

Function
REQ-014 SHALL buffer input in a 4-entry FIFO; transfer when s_valid && s_ready; s_ready = (count < 4).
REQ-015 Simultaneous push and pop SHALL both occur, count unchanged; push when full SHALL be impossible (s_ready low).
REQ-016 SHALL hold two registers A (current), B (next) and phase counter k, 0..2^INTERP_LOG2-1.
REQ-017 States SHALL be IDLE, PRIME, RUN, STARVE.
REQ-018 IDLE: when count ≥ 2, pop into A, go PRIME; PRIME: pop into B, k=0, go RUN (no out_en needed).
REQ-019 RUN, on out_en: compute y = A + (((B−A)·k) >>> INTERP_LOG2), diff INPUT_WIDTH+1 bits, arithmetic shift, y fits INPUT_WIDTH; then k increments.
REQ-020 RUN, out_en with k at max: k wraps to 0; if FIFO non-empty, A<=B, B<=pop; else A<=B, go STARVE, pulse underflow.
REQ-021 STARVE: each out_en outputs y = B; on first cycle FIFO non-empty, A<=B, B<=pop, k=0, go RUN.
REQ-022 In IDLE/PRIME, out_en SHALL still pulse dac_valid with dac_out = midscale (1<<(OUTPUT_WIDTH−1)).
REQ-023 Output code SHALL be top OUTPUT_WIDTH bits of y (quantised per REQ-029), MSB inverted (offset binary).
REQ-024 dac_out and dac_valid SHALL be registered, 1 cycle after out_en; dac_out holds between strobes.
REQ-025 Pop in PRIME and pop at wrap SHALL never coincide; pop and push to FIFO may coincide per REQ-015.

Reset
REQ-026 RST high SHALL, at next edge: flush FIFO (count 0), state IDLE, A=B=0, k=0, dac_out=midscale, dac_valid=0, underflow=0, active=0.
REQ-027 s_ready SHALL be 1 in the cycle after RST deasserts; input during RST SHALL be discarded.
REQ-028 RST mid-RUN/STARVE SHALL abandon interpolation with no further underflow pulse.

Configuration
REQ-029 Macro TX_BACKEND_ROUND_EN defined: quantise by adding 1<<(INPUT_WIDTH−OUTPUT_WIDTH−1) then truncating, saturating to max positive on overflow; undefined: plain truncation of low INPUT_WIDTH−OUTPUT_WIDTH bits, no rounding logic.

Verification (INPUT_WIDTH=12, OUTPUT_WIDTH=8, INTERP_LOG2=2)
REQ-030 Push 0, 1024, 1024; strobe out_en each cycle -> dac_out 0x80,0x90,0xA0,0xB0, then 0xC0 repeated; active=1.
REQ-031 Push only 0, 1024; 5 out_en -> 4 ramp codes, underflow pulses once at 4th wrap, 5th code 0xC0 (STARVE holds B); push 0 -> resumes RUN ramp down 0xC0,0xB0...
REQ-032 Push 4 samples with out_en low -> s_ready 0 after 4th accept; 5th s_valid not accepted; one pop re-raises s_ready next cycle.
REQ-033 A=B=24 (y=24): with TX_BACKEND_ROUND_EN -> 0x82; without -> 0x81. A=B=2040: both -> 0xFF (saturate/truncate to 0x7F).
REQ-034 RST one cycle during RUN with 3 queued -> next cycle dac_out 0x80, s_ready 1, active 0; out_en gives 0x80 until 2 new samples pushed.
